// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Chooses each cycle how the program counter advances (normal, branch, jump,
//   stop) and layers hazard stalls, vectored interrupt entry, ERET and halt on
//   top of the decode request. All PC values are word addresses.
//
//   Optional feature macro: PC_SEQ_PERF_EN enables the three performance
//   counters; when undefined the counter ports read 32'h0 and no counter
//   flops are built.
//
// Ports
//   clk, clr        clock / synchronous active-high reset
//   current_pc      PC of the instruction in decode
//   req_pc_inc      decode request: 00 normal, 01 branch, 10 jump, 11 stop
//   branch_taken    ALU branch result (used with req 01)
//   branch_offset   signed word offset for a branch
//   jump_addr       absolute jump target
//   stall_req       hold the PC this cycle
//   eret            current instruction is ERET
//   irq_req/irq_en  level-sensitive requests and per-line enable mask
//   pc_inc_o        code to the PC register (combinational)
//   abs_addr_o      absolute address to the PC register (combinational)
//   irq_ack         one-hot, one-cycle pulse on interrupt entry
//   irq_active      set while inside a handler
//   epc             saved return PC
//   halted          sequencer is in HALT
//   stall_cycles, taken_branches, irq_count   performance counters
module pc_sequencer #(
    parameter int unsigned NIRQ           = 4,
    parameter logic [31:0] HANDLER_BASE   = 32'h0000_0100,
    parameter logic [31:0] HANDLER_STRIDE = 32'h0000_0010
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     current_pc,
    input  logic [1:0]      req_pc_inc,
    input  logic            branch_taken,
    input  logic [31:0]     branch_offset,
    input  logic [31:0]     jump_addr,
    input  logic            stall_req,
    input  logic            eret,
    input  logic [NIRQ-1:0] irq_req,
    input  logic [NIRQ-1:0] irq_en,
    output logic [1:0]      pc_inc_o,
    output logic [31:0]     abs_addr_o,
    output logic [NIRQ-1:0] irq_ack,
    output logic            irq_active,
    output logic [31:0]     epc,
    output logic            halted,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     taken_branches,
    output logic [31:0]     irq_count
);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t          r_state;
    logic [NIRQ-1:0] r_irq_ack;
    logic            r_irq_active;
    logic [31:0]     r_epc;

    logic [NIRQ-1:0] w_pend;
    logic [3:0]      w_idx;
    logic            w_found;
    logic [NIRQ-1:0] w_ack_vec;
    logic [31:0]     w_seq_next;
    logic [31:0]     w_handler_addr;
    logic            w_take_irq;

    assign w_pend = irq_req & irq_en;

    // Fixed priority: lowest pending index wins.
    always_comb begin
        w_idx     = '0;
        w_found   = 1'b0;
        w_ack_vec = '0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (w_pend[i] && !w_found) begin
                w_idx        = 4'(i);
                w_found      = 1'b1;
                w_ack_vec[i] = 1'b1;
            end
        end
    end

    assign w_handler_addr = HANDLER_BASE + 32'(w_idx) * HANDLER_STRIDE;

    // Address the interrupted instruction would have continued to; a taken
    // branch or jump survives interrupt entry through epc.
    always_comb begin
        w_seq_next = current_pc + 32'd1;
        if (req_pc_inc == 2'b01 && branch_taken)
            w_seq_next = current_pc + 32'd1 + branch_offset;
        else if (req_pc_inc == 2'b10)
            w_seq_next = jump_addr;
    end

    always_comb begin
        pc_inc_o   = req_pc_inc;
        abs_addr_o = jump_addr;
        w_take_irq = 1'b0;
        if (r_state == ST_HALT) begin
            pc_inc_o = 2'b11;
        end else if (stall_req) begin
            // Hold via an absolute reload so the stop code never appears.
            pc_inc_o   = 2'b10;
            abs_addr_o = current_pc;
        end else if (eret) begin
            pc_inc_o   = 2'b10;
            abs_addr_o = r_epc;
        end else if (req_pc_inc == 2'b11) begin
            pc_inc_o = 2'b11;
        end else if (w_found && !r_irq_active) begin
            pc_inc_o   = 2'b10;
            abs_addr_o = w_handler_addr;
            w_take_irq = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_RUN;
            r_irq_ack    <= '0;
            r_irq_active <= 1'b0;
            r_epc        <= '0;
        end else begin
            r_irq_ack <= '0;
            if (r_state == ST_RUN && !stall_req) begin
                if (eret) begin
                    r_irq_active <= 1'b0;
                end else if (req_pc_inc == 2'b11) begin
                    r_state <= ST_HALT;
                end else if (w_take_irq) begin
                    r_epc        <= w_seq_next;
                    r_irq_active <= 1'b1;
                    r_irq_ack    <= w_ack_vec;
                end
            end
        end
    end

    assign irq_ack    = r_irq_ack;
    assign irq_active = r_irq_active;
    assign epc        = r_epc;
    assign halted     = (r_state == ST_HALT);

`ifdef PC_SEQ_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_taken_branches;
    logic [31:0] r_irq_count;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_stall_cycles   <= '0;
            r_taken_branches <= '0;
            r_irq_count      <= '0;
        end else if (r_state == ST_RUN) begin
            if (stall_req)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (!stall_req && !eret && req_pc_inc == 2'b01 && branch_taken && !w_take_irq)
                r_taken_branches <= r_taken_branches + 32'd1;
            if (w_take_irq)
                r_irq_count <= r_irq_count + 32'd1;
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign taken_branches = r_taken_branches;
    assign irq_count      = r_irq_count;
`else
    assign stall_cycles   = '0;
    assign taken_branches = '0;
    assign irq_count      = '0;
`endif

endmodule
